// File: rtl/candidate_window_scanner_if.sv
// Scanner port bundle: window origin handshake, classifier verdict, candidate FIFO head and status.
interface candidate_window_scanner_if #(
    parameter int COORD_WIDTH = 8
);
    logic                   frame_ready;
    logic                   win_valid;
    logic [COORD_WIDTH-1:0] win_x;
    logic [COORD_WIDTH-1:0] win_y;
    logic                   win_ready;
    logic                   result_valid;
    logic                   candidate;
    logic                   cand_valid;
    logic [COORD_WIDTH-1:0] cand_x;
    logic [COORD_WIDTH-1:0] cand_y;
    logic                   cand_ready;
    logic                   busy;
    logic                   frame_done;
    logic [7:0]             drop_count;

    modport master (
        input  frame_ready, win_ready, result_valid, candidate, cand_ready,
        output win_valid, win_x, win_y, cand_valid, cand_x, cand_y, busy, frame_done, drop_count
    );

    modport slave (
        output frame_ready, win_ready, result_valid, candidate, cand_ready,
        input  win_valid, win_x, win_y, cand_valid, cand_x, cand_y, busy, frame_done, drop_count
    );
endinterface

// File: rtl/candidate_window_scanner.sv
// Raster-scans window origins into the cascade classifier and queues passing origins in an FWFT FIFO.
// 1 cycle frame_ready->first win_valid and verdict->next win_valid; holds origin until win_ready; drops hits when FIFO full.
module candidate_window_scanner #(
    parameter int IWIDTH      = 64,
    parameter int IHEIGHT     = 48,
    parameter int WIN_SIZE    = 24,
    parameter int STEP        = 1,
    parameter int COORD_WIDTH = 8,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk_fpga,
    input  logic                        reset_fpga,
    candidate_window_scanner_if.master  bus
);
    localparam int CW1   = COORD_WIDTH + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PW1   = PTR_W + 1;

    localparam logic [COORD_WIDTH:0] XMAX   = CW1'(IWIDTH - WIN_SIZE);
    localparam logic [COORD_WIDTH:0] YMAX   = CW1'(IHEIGHT - WIN_SIZE);
    localparam logic [COORD_WIDTH:0] STEP_W = CW1'(STEP);
    localparam logic [PTR_W:0]       PTR_ONE = PW1'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state;
    logic [COORD_WIDTH:0] x_next;
    logic [COORD_WIDTH:0] y_next;
    logic                 x_wrap;
    logic                 y_wrap;
    logic                 push;

    // One extra bit so origin + STEP can never wrap past the limit.
    assign x_next = {1'b0, bus.win_x} + STEP_W;
    assign y_next = {1'b0, bus.win_y} + STEP_W;
    assign x_wrap = x_next > XMAX;
    assign y_wrap = y_next > YMAX;
    assign push   = (state == WAIT) && bus.result_valid && bus.candidate;

    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            state          <= IDLE;
            bus.win_valid  <= 1'b0;
            bus.win_x      <= '0;
            bus.win_y      <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.frame_ready) begin
                        state         <= ISSUE;
                        bus.win_valid <= 1'b1;
                        bus.win_x     <= '0;
                        bus.win_y     <= '0;
                        bus.busy      <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.win_ready) begin
                        state         <= WAIT;
                        bus.win_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.result_valid) begin
                        if (x_wrap && y_wrap) begin
                            state          <= DONE;
                            bus.frame_done <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            bus.win_valid <= 1'b1;
                            if (x_wrap) begin
                                bus.win_x <= '0;
                                bus.win_y <= y_next[COORD_WIDTH-1:0];
                            end else begin
                                bus.win_x <= x_next[COORD_WIDTH-1:0];
                            end
                        end
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    bus.frame_done <= 1'b0;
                    bus.busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [2*COORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]           wr_ptr;
    logic [PTR_W:0]           rd_ptr;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     pop;
    logic                     fifo_wr;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = !fifo_empty && bus.cand_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign fifo_wr    = push && (!fifo_full || pop);

    assign bus.cand_valid           = !fifo_empty;
    assign {bus.cand_x, bus.cand_y} = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk_fpga) begin
        if (fifo_wr) begin
            mem[wr_ptr[PTR_W-1:0]] <= {bus.win_x, bus.win_y};
        end
    end

    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            bus.drop_count <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && fifo_full && !pop && (bus.drop_count != 8'hFF)) begin
                bus.drop_count <= bus.drop_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_candidate_window_scanner.sv
// Bench for two scanner configurations (28x26 step 2, and defaults) against a frame-level origin/FIFO model.
module tb_candidate_window_scanner;
    typedef struct packed { logic [7:0] x; logic [7:0] y; } xy_t;
    typedef struct packed {
        logic       wv;
        logic [7:0] wx;
        logic [7:0] wy;
        logic       busy;
        logic       fd;
        logic       cv;
        logic [7:0] cx;
        logic [7:0] cy;
        logic [7:0] drop;
    } obs_t;
    typedef struct packed { logic fr; logic wr; logic rv; logic cand; logic crdy; } drv_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    candidate_window_scanner_if #(.COORD_WIDTH(8)) bs ();
    candidate_window_scanner_if #(.COORD_WIDTH(8)) bd ();

    drv_t drv [2];
    obs_t obs [2];

    assign bs.frame_ready  = drv[0].fr;
    assign bs.win_ready    = drv[0].wr;
    assign bs.result_valid = drv[0].rv;
    assign bs.candidate    = drv[0].cand;
    assign bs.cand_ready   = drv[0].crdy;
    assign bd.frame_ready  = drv[1].fr;
    assign bd.win_ready    = drv[1].wr;
    assign bd.result_valid = drv[1].rv;
    assign bd.candidate    = drv[1].cand;
    assign bd.cand_ready   = drv[1].crdy;

    candidate_window_scanner #(
        .IWIDTH(28), .IHEIGHT(26), .WIN_SIZE(24), .STEP(2), .COORD_WIDTH(8), .FIFO_DEPTH(8)
    ) dut_s (
        .clk_fpga   (clk),
        .reset_fpga (rst_n),
        .bus        (bs.master)
    );

    candidate_window_scanner dut_d (
        .clk_fpga   (clk),
        .reset_fpga (rst_n),
        .bus        (bd.master)
    );

    // Model state always describes the DUT as it will be after the next rising edge.
    xy_t exp_q   [2][$];
    xy_t fifo_q  [2][$];
    xy_t hs_log  [2][$];
    xy_t pop_log [2][$];
    int  m_drop [2];
    bit  m_idle [2];
    bit  m_issue [2];
    bit  m_wait [2];
    bit  m_done [2];
    xy_t m_cur [2];
    bit  acc [2];
    int  hold_cnt [2];
    bit  hold_en [2];
    bit  fr_req [2];
    int  cand_mode [2];
    int  crdy_mode [2];
    int  fd_cnt [2];

    int n_checks = 0;
    int n_fail   = 0;

    xy_t lit6 [6] = '{16'h0000, 16'h0200, 16'h0400, 16'h0002, 16'h0202, 16'h0402};
    xy_t lit8 [8] = '{16'h0202, 16'h0402, 16'h0000, 16'h0200, 16'h0400, 16'h0002, 16'h0202, 16'h0402};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            exp_q[g].delete();
            fifo_q[g].delete();
            m_drop[g]   = 0;
            m_idle[g]   = 1'b1;
            m_issue[g]  = 1'b0;
            m_wait[g]   = 1'b0;
            m_done[g]   = 1'b0;
            acc[g]      = 1'b0;
            hold_cnt[g] = 0;
        end
    endtask

    task automatic build_origins(input int g);
        int xm;
        int ym;
        int st;
        xm = (g == 0 ? 28 : 64) - 24;
        ym = (g == 0 ? 26 : 48) - 24;
        st = (g == 0) ? 2 : 1;
        exp_q[g].delete();
        for (int y = 0; y <= ym; y += st)
            for (int x = 0; x <= xm; x += st)
                exp_q[g].push_back('{x: 8'(x), y: 8'(y)});
    endtask

    task automatic capture();
        obs[0] = '{wv: bs.win_valid, wx: bs.win_x, wy: bs.win_y, busy: bs.busy, fd: bs.frame_done,
                   cv: bs.cand_valid, cx: bs.cand_x, cy: bs.cand_y, drop: bs.drop_count};
        obs[1] = '{wv: bd.win_valid, wx: bd.win_x, wy: bd.win_y, busy: bd.busy, fd: bd.frame_done,
                   cv: bd.cand_valid, cx: bd.cand_x, cy: bd.cand_y, drop: bd.drop_count};
    endtask

    function automatic logic verdict(input int g, input xy_t o);
        case (cand_mode[g])
            1:       return 1'b1;
            2:       return (o == 16'h0200) || (o == 16'h0402);
            default: return 1'b0;
        endcase
    endfunction

    // Classifier/consumer behaviour: verdict one cycle after acceptance, optional win_ready stalls.
    task automatic drive();
        capture();
        for (int g = 0; g < 2; g++) begin
            drv_t d;
            bit   real_rv;
            d       = '0;
            real_rv = acc[g];
            d.wr    = 1'b1;
            if (acc[g]) begin
                d.rv   = 1'b1;
                d.cand = verdict(g, m_cur[g]);
                acc[g] = 1'b0;
            end
            if (obs[g].wv && hold_en[g] && hold_cnt[g] < 5) begin
                d.wr   = 1'b0;
                d.rv   = 1'b1;
                d.cand = 1'b1;
                d.fr   = 1'b1;
                hold_cnt[g]++;
            end else if (obs[g].wv) begin
                hold_cnt[g] = 0;
            end
            if (fr_req[g]) begin
                d.fr      = 1'b1;
                fr_req[g] = 1'b0;
            end
            case (crdy_mode[g])
                1:       d.crdy = 1'b1;
                2:       d.crdy = real_rv && (fifo_q[g].size() == 8);
                default: d.crdy = 1'b0;
            endcase
            drv[g] = d;
        end
    endtask

    task automatic compare();
        capture();
        for (int g = 0; g < 2; g++) begin
            drv_t d;
            bit   pop;
            bit   push;
            check($sformatf("busy[%0d]", g), obs[g].busy, !m_idle[g]);
            check($sformatf("win_valid[%0d]", g), obs[g].wv, m_issue[g]);
            if (m_issue[g] && exp_q[g].size() != 0)
                check($sformatf("win_xy[%0d]", g), {obs[g].wx, obs[g].wy}, exp_q[g][0]);
            check($sformatf("frame_done[%0d]", g), obs[g].fd, m_done[g]);
            if (obs[g].fd) fd_cnt[g]++;
            check($sformatf("cand_valid[%0d]", g), obs[g].cv, fifo_q[g].size() != 0);
            if (fifo_q[g].size() != 0)
                check($sformatf("cand_xy[%0d]", g), {obs[g].cx, obs[g].cy}, fifo_q[g][0]);
            check($sformatf("drop_count[%0d]", g), obs[g].drop, m_drop[g]);

            d    = drv[g];
            pop  = (fifo_q[g].size() != 0) && d.crdy;
            push = m_wait[g] && d.rv && d.cand;
            if (pop) pop_log[g].push_back(fifo_q[g].pop_front());
            if (push) begin
                if (fifo_q[g].size() < 8) fifo_q[g].push_back(m_cur[g]);
                else if (m_drop[g] < 255) m_drop[g]++;
            end
            if (m_done[g]) begin
                m_done[g] = 1'b0;
                m_idle[g] = 1'b1;
            end else if (m_idle[g]) begin
                if (d.fr) begin
                    build_origins(g);
                    m_idle[g]  = 1'b0;
                    m_issue[g] = 1'b1;
                end
            end else if (m_issue[g]) begin
                if (d.wr) begin
                    m_cur[g] = exp_q[g].pop_front();
                    hs_log[g].push_back(m_cur[g]);
                    m_issue[g] = 1'b0;
                    m_wait[g]  = 1'b1;
                    acc[g]     = 1'b1;
                end
            end else if (m_wait[g]) begin
                if (d.rv) begin
                    m_wait[g] = 1'b0;
                    if (exp_q[g].size() == 0) m_done[g] = 1'b1;
                    else m_issue[g] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        compare();
    endtask

    task automatic reset_checks();
        capture();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst_win_valid[%0d]", g), obs[g].wv, 0);
            check($sformatf("rst_win_x[%0d]", g), obs[g].wx, 0);
            check($sformatf("rst_win_y[%0d]", g), obs[g].wy, 0);
            check($sformatf("rst_busy[%0d]", g), obs[g].busy, 0);
            check($sformatf("rst_frame_done[%0d]", g), obs[g].fd, 0);
            check($sformatf("rst_cand_valid[%0d]", g), obs[g].cv, 0);
            check($sformatf("rst_cand_x[%0d]", g), obs[g].cx, 0);
            check($sformatf("rst_cand_y[%0d]", g), obs[g].cy, 0);
            check($sformatf("rst_drop_count[%0d]", g), obs[g].drop, 0);
        end
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        drv[0] = '0;
        drv[1] = '0;
        model_reset();
        #1;
        reset_checks();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input int g, input int budget);
        int n;
        n         = 0;
        fd_cnt[g] = 0;
        hs_log[g].delete();
        pop_log[g].delete();
        fr_req[g] = 1'b1;
        do begin
            tick();
            n++;
        end while (!obs[g].fd && n < budget);
        check($sformatf("frame_done_reached[%0d]", g), obs[g].fd, 1);
        repeat (3) tick();
        check($sformatf("frame_done_pulses[%0d]", g), fd_cnt[g], 1);
    endtask

    task automatic check_origins6(input string tag);
        check({tag, "_count"}, hs_log[0].size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < hs_log[0].size())
                check($sformatf("%s_origin%0d", tag, i), hs_log[0][i], lit6[i]);
    endtask

    initial begin
        int n;
        drv[0] = '0;
        drv[1] = '0;
        for (int g = 0; g < 2; g++) begin
            hold_en[g]   = 1'b0;
            fr_req[g]    = 1'b0;
            cand_mode[g] = 0;
            crdy_mode[g] = 0;
        end
        model_reset();
        #2;
        apply_reset();
        repeat (2) tick();

        // Small frame, no candidates: exact origin order and a single frame_done.
        run_frame(0, 200);
        check_origins6("scan");

        // Hits on (2,0) and (4,2) flow straight through the FIFO.
        cand_mode[0] = 2;
        crdy_mode[0] = 1;
        run_frame(0, 200);
        check("hits_count", pop_log[0].size(), 2);
        if (pop_log[0].size() == 2) begin
            check("hit0", pop_log[0][0], 16'h0200);
            check("hit1", pop_log[0][1], 16'h0402);
        end
        check("hits_drop", obs[0].drop, 0);

        // Stalled win_ready with stray frame_ready/result_valid while the origin is presented.
        cand_mode[0] = 0;
        crdy_mode[0] = 0;
        hold_en[0]   = 1'b1;
        run_frame(0, 300);
        hold_en[0] = 1'b0;
        check_origins6("stall");
        check("stall_cand_valid", obs[0].cv, 0);

        // Reset mid-scan while waiting for a verdict with three entries queued.
        cand_mode[0] = 1;
        fr_req[0]    = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(fifo_q[0].size() == 3 && m_wait[0]) && n < 100);
        check("midscan_reached", fifo_q[0].size() == 3 && m_wait[0], 1);
        @(posedge clk);
        #1;
        capture();
        check("pre_rst_busy", obs[0].busy, 1);
        check("pre_rst_cand_valid", obs[0].cv, 1);
        apply_reset();
        repeat (3) tick();

        // Fill to 8, then every further push is paired with a pop: no drops.
        cand_mode[0] = 1;
        crdy_mode[0] = 0;
        run_frame(0, 200);
        crdy_mode[0] = 2;
        run_frame(0, 200);
        check("full_pp_drop", obs[0].drop, 0);
        crdy_mode[0] = 0;
        pop_log[0].delete();
        crdy_mode[0] = 1;
        repeat (12) tick();
        crdy_mode[0] = 0;
        check("full_pp_occupancy", pop_log[0].size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < pop_log[0].size())
                check($sformatf("full_pp_entry%0d", i), pop_log[0][i], lit8[i]);

        // Default geometry, every window a hit, nobody draining: 1025 hits, 8 kept, drops saturate.
        cand_mode[1] = 1;
        crdy_mode[1] = 0;
        run_frame(1, 5000);
        check("sat_drop_count", obs[1].drop, 255);
        check("sat_cand_valid", obs[1].cv, 1);
        pop_log[1].delete();
        crdy_mode[1] = 1;
        repeat (12) tick();
        check("sat_kept", pop_log[1].size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < pop_log[1].size())
                check($sformatf("sat_entry%0d", i), pop_log[1][i], {8'(i), 8'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
